// File: rtl/axi_pkg.sv
// Shared types and constants for the four-master AXI read-address/read-data arbiter.
package axi_pkg;

  localparam int NUM_MASTERS = 4;

  typedef logic [1:0] mst_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  function automatic mst_idx_t onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) onehot_to_idx = mst_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Master-side and slave-mux-side read channel signals of the arbiter.
interface axi_read_arbiter_if #(
  parameter int ADDR_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] m0_ARADDR, m1_ARADDR, m2_ARADDR, m3_ARADDR;
  logic m0_ARVALID, m1_ARVALID, m2_ARVALID, m3_ARVALID;
  logic m0_RREADY, m1_RREADY, m2_RREADY, m3_RREADY;
  logic m0_ARREADY, m1_ARREADY, m2_ARREADY, m3_ARREADY;
  logic m0_RVALID, m1_RVALID, m2_RVALID, m3_RVALID;

  logic [ADDR_WIDTH-1:0] s_ARADDR;
  logic s_ARVALID, s_RREADY;
  logic m_ARREADY, m_RVALID, m_RLAST;

  // Arbiter side
  modport slave (
    input  m0_ARADDR, m1_ARADDR, m2_ARADDR, m3_ARADDR,
    input  m0_ARVALID, m1_ARVALID, m2_ARVALID, m3_ARVALID,
    input  m0_RREADY, m1_RREADY, m2_RREADY, m3_RREADY,
    output m0_ARREADY, m1_ARREADY, m2_ARREADY, m3_ARREADY,
    output m0_RVALID, m1_RVALID, m2_RVALID, m3_RVALID,
    output s_ARADDR, s_ARVALID, s_RREADY,
    input  m_ARREADY, m_RVALID, m_RLAST
  );

  // Masters plus slave read mux side
  modport master (
    output m0_ARADDR, m1_ARADDR, m2_ARADDR, m3_ARADDR,
    output m0_ARVALID, m1_ARVALID, m2_ARVALID, m3_ARVALID,
    output m0_RREADY, m1_RREADY, m2_RREADY, m3_RREADY,
    input  m0_ARREADY, m1_ARREADY, m2_ARREADY, m3_ARREADY,
    input  m0_RVALID, m1_RVALID, m2_RVALID, m3_RVALID,
    input  s_ARADDR, s_ARVALID, s_RREADY,
    output m_ARREADY, m_RVALID, m_RLAST
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin winner selection: search starts at the master after last_owner.
module rr_priority_pick
  import axi_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req_i,
  input  mst_idx_t               last_owner_i,
  output mst_idx_t               winner_o,
  output logic                   valid_o
);

  always_comb begin
    mst_idx_t idx;
    idx      = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = last_owner_i + mst_idx_t'(i);
      if (!valid_o && req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Four-master AXI read arbiter: one owner holds the address then data channel
// until its last read beat, with round-robin hand-over through a single IDLE cycle.
//
// state | meaning
// IDLE  | no owner, arbitrate pending ARVALIDs
// ADDR  | owner drives the address channel
// DATA  | owner receives read beats until RLAST handshake
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi_read_arbiter_if.slave      bus,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   busy
);

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  mst_idx_t               last_owner_q, last_owner_d;

  logic [ADDR_WIDTH-1:0]  araddr [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] arvalid, rready, arready, rvalid;
  logic [ADDR_WIDTH-1:0]  s_araddr;
  logic                   s_arvalid, s_rready;
  mst_idx_t               owner, pick_idx;
  logic                   pick_valid;

  assign araddr[0] = bus.m0_ARADDR;
  assign araddr[1] = bus.m1_ARADDR;
  assign araddr[2] = bus.m2_ARADDR;
  assign araddr[3] = bus.m3_ARADDR;
  assign arvalid   = {bus.m3_ARVALID, bus.m2_ARVALID, bus.m1_ARVALID, bus.m0_ARVALID};
  assign rready    = {bus.m3_RREADY, bus.m2_RREADY, bus.m1_RREADY, bus.m0_RREADY};

  assign owner = onehot_to_idx(grant_q);

  rr_priority_pick u_pick (
    .req_i        (arvalid),
    .last_owner_i (last_owner_q),
    .winner_o     (pick_idx),
    .valid_o      (pick_valid)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_owner_q <= mst_idx_t'(NUM_MASTERS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    s_araddr     = '0;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    arready      = '0;
    rvalid       = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = ADDR;
        end
      end
      ADDR: begin
        s_araddr       = araddr[owner];
        s_arvalid      = arvalid[owner];
        arready[owner] = bus.m_ARREADY;
        if (s_arvalid && bus.m_ARREADY) state_d = DATA;
      end
      DATA: begin
        s_rready      = rready[owner];
        rvalid[owner] = bus.m_RVALID;
        // Grant is only released on the handshaken last beat.
        if (bus.m_RVALID && s_rready && bus.m_RLAST) begin
          state_d      = IDLE;
          last_owner_d = owner;
          grant_d      = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign bus.s_ARADDR   = s_araddr;
  assign bus.s_ARVALID  = s_arvalid;
  assign bus.s_RREADY   = s_rready;
  assign bus.m0_ARREADY = arready[0];
  assign bus.m1_ARREADY = arready[1];
  assign bus.m2_ARREADY = arready[2];
  assign bus.m3_ARREADY = arready[3];
  assign bus.m0_RVALID  = rvalid[0];
  assign bus.m1_RVALID  = rvalid[1];
  assign bus.m2_RVALID  = rvalid[2];
  assign bus.m3_RVALID  = rvalid[3];

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, read address width; bits [ADDR_WIDTH-1 -: 3] select the slave downstream.
REQ-002 Port ACLK  input  1  single clock; all state updates on the rising edge.
REQ-003 Port ARESETn  input  1  reset, asynchronous and active-low.
REQ-004 Ports mN_ARADDR, N=0..3  input  ADDR_WIDTH  read address from master N.
REQ-005 Ports mN_ARVALID, N=0..3  input  1  read-address valid from master N.
REQ-006 Ports mN_RREADY, N=0..3  input  1  read-data ready from master N.
REQ-007 Ports mN_ARREADY, N=0..3  output  1  read-address ready to master N.
REQ-008 Ports mN_RVALID, N=0..3  output  1  read-data valid to master N.
REQ-009 Port s_ARADDR  output  ADDR_WIDTH  address of the granted master, to the slave read mux.
REQ-010 Port s_ARVALID  output  1  address valid of the granted master, to the slave read mux.
REQ-011 Port s_RREADY  output  1  data ready of the granted master, to the slave read mux.
REQ-012 Port m_ARREADY  input  1  address ready returned by the slave read mux.
REQ-013 Port m_RVALID  input  1  data valid returned by the slave read mux.
REQ-014 Port m_RLAST  input  1  last beat of burst returned by the slave read mux.
REQ-015 Port grant  output  4  one-hot registered owner; 0 when no owner.
REQ-016 Port busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have three states:
- IDLE: no owner.
- ADDR: owner holds the address channel.
- DATA: owner holds the data channel until its last beat.
REQ-018 IDLE: when any mN_ARVALID is high, the arbiter SHALL register the winner into grant and move to ADDR on the next edge. With no request, it SHALL stay in IDLE.
REQ-019 Winner selection SHALL be round-robin. Priority order is last_owner+1, +2, +3, +4 (mod 4). The first master in that order with mN_ARVALID high wins.
REQ-020 ADDR: the outputs SHALL follow the owner as below.
- s_ARADDR = owner ARADDR.
- s_ARVALID = owner ARVALID.
- owner ARREADY = m_ARREADY.
- All other mN_ARREADY = 0.
REQ-021 ADDR→DATA SHALL occur on the edge where s_ARVALID and m_ARREADY are both high.
REQ-022 DATA: the outputs SHALL follow the owner as below.
- s_RREADY = owner RREADY.
- owner RVALID = m_RVALID.
- All other mN_RVALID = 0.
- s_ARVALID = 0.
REQ-023 DATA→IDLE SHALL occur on the edge where m_RVALID, s_RREADY and m_RLAST are all high. On that edge, last_owner SHALL take the owner index and grant SHALL clear.
REQ-024 A beat without RLAST SHALL keep the FSM in DATA. m_RVALID high while s_RREADY is low SHALL cause no transition.
REQ-025 Requests from non-owners during ADDR or DATA SHALL be ignored. They SHALL be arbitrated in the first IDLE cycle, so there is exactly one IDLE bubble between bursts.
REQ-026 Grant SHALL NOT be revoked until REQ-023, even if the owner deasserts ARVALID.
REQ-027 Minimum latency SHALL be as follows.
- mN_ARVALID high in IDLE (cycle 0) → s_ARVALID high in cycle 1.
- Single-beat read with ready slave → back in IDLE in cycle 3.
REQ-028 In IDLE, s_ARADDR SHALL be 0, and s_ARVALID, s_RREADY and all mN_ARREADY and mN_RVALID SHALL be 0.

Reset
REQ-029 Asserting ARESETn low SHALL immediately force all of the following, including mid-burst:
- FSM to IDLE.
- grant=0, busy=0.
- last_owner=3, so master 0 has highest priority after reset.
- All outputs to 0.
REQ-030 After ARESETn deasserts, the block SHALL begin arbitration on the first rising edge.

Structure
REQ-031 The shared package axi_pkg SHALL hold:
- the FSM state enum (IDLE, ADDR, DATA);
- the constant NUM_MASTERS=4;
- the master index type (2 bits).
REQ-032 Round-robin selection SHALL live in one combinational sub-module, rr_priority_pick, with these ports:
- inputs: request vector [3:0], last_owner [1:0];
- outputs: winner index [1:0], valid.
REQ-033 Grant, last_owner and state SHALL be flops. Output muxing SHALL be combinational from the flops and inputs, with no other storage.

Verification
REQ-034 Reset, then m0 and m2 ARVALID both high with m_ARREADY=1 and 1-beat RLAST → grant=0001 in cycle 1, s_ARADDR=m0_ARADDR; after m0's burst, grant=0100.
REQ-035 All four ARVALID held high, 1-beat bursts → grant sequence 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between each.
REQ-036 m1 granted, 4-beat burst with s_RREADY toggling 1,0,1,1,1 and RLAST on beat 4 → FSM stays in DATA until beat 4 handshake; only m1_RVALID is ever high.
REQ-037 m3 in DATA and ARESETn pulsed low for 1 cycle mid-burst → all outputs 0 immediately; next request from m0 and m3 together grants m0.
REQ-038 m2 in ADDR with m_ARREADY=0 for 5 cycles, m0 requesting meanwhile → s_ARVALID held, grant=0100 unchanged, m0_ARREADY=0 throughout.
